demux16_stream: RTL
===================

// Module: demux16_stream
// PURPOSE
//   16-way stream demultiplexer: the write/distribute side paired with the 16:1 select muxes.
//   Accepts one N-bit word per cycle on a valid/ready input tagged with a 4-bit destination.
//   Delivers it to exactly one of 16 valid/ready output channels through a registered output slot.
//   Words addressed to a disabled channel are dropped and counted.
// PARAMETERS
//   N        32   data width in bits
//   CNT_W    16   width of the saturating drop counter
// PORTS
//   clk        in   1       single clock; all state updates on posedge
//   rst_n      in   1       synchronous, active-low reset
//   in_data    in   N       input word
//   in_dest    in   4       destination channel 0..15
//   in_valid   in   1       input word present
//   in_ready   out  1       block accepts word this cycle
//   chan_en    in   16      per-channel enable; bit i=0 -> words for channel i are dropped
//   out_data   out  N       shared output data bus, broadcast to all channels
//   out_valid  out  16      one-hot (or zero) per-channel valid
//   out_ready  in   16      per-channel ready
//   drop_cnt   out  CNT_W   number of dropped words, saturating
//   drop_clr   in   1       synchronous clear of drop_cnt
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): slot empty, out_valid=0, out_data=0, drop_cnt=0, skid empty.
//     While rst_n=0, in_ready=0.
//   - Input accept: in_valid && in_ready. Output transfer: out_valid[i] && out_ready[i].
//   - Output slot holds {data, dest, full}. out_valid[i] = full && (dest==i); out_data = slot data.
//     Only one out_valid bit is ever high.
//   - Accepted word with chan_en[in_dest]=1 loads the slot; first visible the next cycle (latency 1).
//   - Accepted word with chan_en[in_dest]=0 is consumed and discarded; it never loads the slot.
//     drop_cnt increments by 1, saturating at 2^CNT_W-1.
//   - A word that has already loaded the slot is not affected by later chan_en changes.
//   - Without DEMUX16_SKID_EN:
//       in_ready = !full || out_ready[dest].
//       Same-cycle drain+load supports full throughput, one word/cycle.
//       in_ready depends combinationally on out_ready.
//   - drop_clr=1: drop_cnt becomes 0 next cycle. A drop in the same cycle is lost; clear wins.
//   - Stall: while full && !out_ready[dest], out_data and out_valid hold stable.
//   - Reset mid-transfer: slot and skid contents are discarded, with no partial output.
// CONFIGURATION
//   DEMUX16_SKID_EN defined:
//     - Adds a 1-entry skid register ahead of the slot.
//     - in_ready = !skid_full, a direct register output with no combinational path from out_ready.
//     - When the slot is blocked, an accepted word is parked in the skid.
//     - The skid moves to the slot when the slot drains, so words stay in order.
//     - Latency is still 1 cycle when the skid is empty; full throughput is kept.
//     - Drop decisions and counting are made at input accept.
//   DEMUX16_SKID_EN undefined: no skid register; in_ready follows the BEHAVIOUR rule above.
// STRUCTURE
//   demux16_pkg:
//     - localparam NUM_CHAN=16
//     - typedef logic [3:0] chan_sel_t
//     - function onehot16(chan_sel_t) -> logic[15:0]
//   Sub-module demux16_slot:
//     - 1-entry {data,dest} register with full flag, load/drain ports.
//     - Instantiated once for the output slot and a second time for the skid under DEMUX16_SKID_EN.
//   Top level: accept/drop decode, drop counter, out_valid decode via onehot16.
// TESTING (run each with and without DEMUX16_SKID_EN)
//   1. Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, drop_cnt=0.
//   2. Single word: data=32'hA5A5_0003, dest=3, all ready, all enabled
//      -> next cycle out_valid=16'h0008, out_data=A5A5_0003, then out_valid=0.
//   3. Streaming: dests 0..15 back-to-back, all out_ready=1
//      -> 16 transfers in 16 consecutive cycles, in order, one-hot valid each cycle.
//   4. Backpressure on dest 7 (out_ready[7]=0 for 5 cycles):
//      -> out_data held; no loss or duplication.
//      -> no skid: in_ready low until release; with skid: exactly one extra word accepted, then in_ready low.
//   5. Drop: chan_en=16'hFFFB, 3 words to dest 2 -> out_valid stays 0, drop_cnt=3.
//      Then drop_clr=1 together with one more drop -> drop_cnt=0.
//   6. Saturation (CNT_W=4): 20 drops -> drop_cnt=15.
//      Reset asserted while the slot is full and stalled -> slot empty after reset.

Source files
------------

// File: rtl/demux16_pkg.sv
// Shared types and helpers for the 16-way stream demultiplexer.
// Optional skid buffer in the top level is enabled by defining DEMUX16_SKID_EN.
package demux16_pkg;

    localparam int unsigned NUM_CHAN = 16;

    typedef logic [3:0] chan_sel_t;

    function automatic logic [NUM_CHAN-1:0] onehot16(input chan_sel_t sel);
        logic [NUM_CHAN-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux16_slot.sv
// One-entry {data, dest} holding register with a full flag.
// Load has priority over drain, so a same-cycle drain+load keeps the entry full.
module demux16_slot
    import demux16_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  chan_sel_t    load_dest,
    input  logic         drain,
    output logic [N-1:0] data,
    output chan_sel_t    dest,
    output logic         full
);

    logic [N-1:0] data_q;
    chan_sel_t    dest_q;
    logic         full_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            dest_q <= '0;
            full_q <= 1'b0;
        end else if (load) begin
            data_q <= load_data;
            dest_q <= load_dest;
            full_q <= 1'b1;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    assign data = data_q;
    assign dest = dest_q;
    assign full = full_q;

endmodule

// File: rtl/demux16_stream.sv
// 16-way stream demultiplexer with a registered output slot and a saturating drop counter.
// Define DEMUX16_SKID_EN to add a skid register that removes the out_ready -> in_ready path.
module demux16_stream
    import demux16_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_data,
    input  chan_sel_t           in_dest,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_CHAN-1:0] chan_en,
    output logic [N-1:0]        out_data,
    output logic [NUM_CHAN-1:0] out_valid,
    input  logic [NUM_CHAN-1:0] out_ready,
    output logic [CNT_W-1:0]    drop_cnt,
    input  logic                drop_clr
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [N-1:0]     slot_data;
    chan_sel_t        slot_dest;
    logic             slot_full;
    logic             slot_drain;
    logic             slot_load;
    logic [N-1:0]     slot_ld_data;
    chan_sel_t        slot_ld_dest;
    logic             accept;
    logic             en_hit;
    logic             drop;
    logic [CNT_W-1:0] cnt_q;

    assign slot_drain = slot_full && out_ready[slot_dest];
    assign en_hit     = chan_en[in_dest];
    assign accept     = in_valid && in_ready;
    assign drop       = accept && !en_hit;

`ifdef DEMUX16_SKID_EN
    logic [N-1:0] skid_data;
    chan_sel_t    skid_dest;
    logic         skid_full;
    logic         skid_load;
    logic         skid_drain;
    logic         slot_free;

    assign slot_free  = !slot_full || slot_drain;
    assign in_ready   = rst_n && !skid_full;
    assign skid_drain = skid_full && slot_free;

    // A parked word always goes ahead of anything new, which keeps order.
    always_comb begin
        slot_load    = 1'b0;
        skid_load    = 1'b0;
        slot_ld_data = in_data;
        slot_ld_dest = in_dest;
        if (skid_full) begin
            slot_load    = slot_free;
            slot_ld_data = skid_data;
            slot_ld_dest = skid_dest;
        end else if (accept && en_hit) begin
            if (slot_free) begin
                slot_load = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end
    end

    demux16_slot #(
        .N(N)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .load_data(in_data),
        .load_dest(in_dest),
        .drain    (skid_drain),
        .data     (skid_data),
        .dest     (skid_dest),
        .full     (skid_full)
    );
`else
    assign in_ready     = rst_n && (!slot_full || out_ready[slot_dest]);
    assign slot_load    = accept && en_hit;
    assign slot_ld_data = in_data;
    assign slot_ld_dest = in_dest;
`endif

    demux16_slot #(
        .N(N)
    ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (slot_load),
        .load_data(slot_ld_data),
        .load_dest(slot_ld_dest),
        .drain    (slot_drain),
        .data     (slot_data),
        .dest     (slot_dest),
        .full     (slot_full)
    );

    // Clear wins over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (drop_clr) begin
            cnt_q <= '0;
        end else if (drop && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign drop_cnt  = cnt_q;
    assign out_data  = slot_data;
    assign out_valid = slot_full ? onehot16(slot_dest) : '0;

endmodule
